// File: rtl/hc595_cap_pkg.sv
// Shared widths, segment type and one-hot decoder for the 74HC595 frame capture monitor.
// Combinational helpers only; no latency, no flow control.
package hc595_cap_pkg;

   localparam int CAP_WORD_W = 16;
   localparam int CAP_DIGITS = 8;
   localparam int CAP_SEG_W  = 8;
   localparam int CAP_IDX_W  = $clog2(CAP_DIGITS);

   typedef logic [CAP_SEG_W-1:0] seg_t;

   typedef struct packed {
      logic                 vld;
      logic [CAP_IDX_W-1:0] idx;
   } onehot_t;

   // vld is set only when exactly one bit of sel is high; idx is then its position.
   function automatic onehot_t onehot_idx(input logic [CAP_DIGITS-1:0] sel);
      onehot_t res;
      int      ones;
      res  = '0;
      ones = 0;
      for (int i = 0; i < CAP_DIGITS; i++) begin
         if (sel[i]) begin
            res.idx = CAP_IDX_W'(i);
            ones    = ones + 1;
         end
      end
      res.vld = (ones == 1);
      return res;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop; rise_o marks a synchronized rising edge.
// Pin-to-event latency 2 clk (acted on at the 3rd edge); no backpressure.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic sync_o,
   output logic rise_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic hist_q, hist_d;

   always_comb begin
      meta_d = pin_i;
      sync_d = meta_q;
      hist_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/hc595_frame_capture.sv
// Rebuilds 16-bit 595 line words from sampled sclk/sdata/rclk, decodes digit/segment, keeps a per-digit image.
// Word valid 3 clk after rclk pin rise, decode 1 clk later; pure monitor, no backpressure.
module hc595_frame_capture
   import hc595_cap_pkg::*;
#(
   parameter int WORD_W         = CAP_WORD_W,
   parameter int DIGITS         = CAP_DIGITS,
   parameter int SEG_W          = CAP_SEG_W,
   parameter bit DIG_ACTIVE_LOW = 1'b1,
   parameter int TIMEOUT        = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sclk_in,
   input  logic                    sdata_in,
   input  logic                    rclk_in,
   input  logic                    clr_err_i,
   output logic [WORD_W-1:0]       word_o,
   output logic                    frame_valid_o,
   output logic [4:0]              bit_count_o,
   output logic                    len_err_o,
   output logic                    sel_err_o,
   output logic [2:0]              digit_o,
   output logic [SEG_W-1:0]        seg_o,
   output logic [DIGITS*SEG_W-1:0] seg_image_o,
   output logic                    idle_o
);

   localparam int                TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT - 1);
   localparam logic [4:0]        LEN_OK  = 5'(WORD_W);

   logic sclk_ev, rclk_ev, sdata_sync;
   logic unused_sclk_sync, unused_rclk_sync, unused_sdata_rise;

   edge_sync u_sclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (sclk_in),
      .sync_o (unused_sclk_sync),
      .rise_o (sclk_ev)
   );

   edge_sync u_sdata_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (sdata_in),
      .sync_o (sdata_sync),
      .rise_o (unused_sdata_rise)
   );

   edge_sync u_rclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (rclk_in),
      .sync_o (unused_rclk_sync),
      .rise_o (rclk_ev)
   );

   logic [WORD_W-1:0]             shift_q, shift_d;
   logic [4:0]                    bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0]             word_q, word_d;
   logic                          frame_valid_q, frame_valid_d;
   logic [4:0]                    bit_count_q, bit_count_d;
   logic                          len_err_q, len_err_d;
   logic                          sel_err_q, sel_err_d;
   logic [2:0]                    digit_q, digit_d;
   logic [SEG_W-1:0]              seg_q, seg_d;
   logic [DIGITS-1:0][SEG_W-1:0]  img_q, img_d;
   logic [TMO_W-1:0]              tmo_q, tmo_d;

   logic                          len_set, sel_set;
   logic [DIGITS-1:0]             dig_field;
   seg_t                          seg_field;
   onehot_t                       dig_oh;

   // Shift is applied before the latch so a coincident sclk/rclk edge lands in the word and the count.
   always_comb begin
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      word_d        = word_q;
      frame_valid_d = 1'b0;
      bit_count_d   = bit_count_q;
      len_set       = 1'b0;
      if (sclk_ev) begin
         shift_d = {shift_q[WORD_W-2:0], sdata_sync};
         if (bit_cnt_q != 5'd31) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
         end
      end
      if (rclk_ev) begin
         word_d        = shift_d;
         frame_valid_d = 1'b1;
         bit_count_d   = bit_cnt_d;
         len_set       = (bit_cnt_d != LEN_OK);
         bit_cnt_d     = 5'd0;
      end
   end

   always_comb begin
      dig_field = word_q[WORD_W-1 -: DIGITS];
      if (DIG_ACTIVE_LOW) begin
         dig_field = ~dig_field;
      end
      seg_field = seg_t'(word_q[SEG_W-1:0]);
      dig_oh    = onehot_idx(CAP_DIGITS'(dig_field));
   end

   // Decode runs one cycle behind the latch, off the registered word.
   always_comb begin
      digit_d = digit_q;
      seg_d   = seg_q;
      img_d   = img_q;
      sel_set = 1'b0;
      if (frame_valid_q) begin
         seg_d = SEG_W'(seg_field);
         if (dig_oh.vld) begin
            digit_d             = 3'(dig_oh.idx);
            img_d[dig_oh.idx]   = SEG_W'(seg_field);
         end else begin
            sel_set = 1'b1;
         end
      end
   end

   // A new error in the same cycle as a clear keeps the flag set.
   always_comb begin
      len_err_d = len_err_q;
      sel_err_d = sel_err_q;
      if (clr_err_i) begin
         len_err_d = 1'b0;
         sel_err_d = 1'b0;
      end
      if (len_set) begin
         len_err_d = 1'b1;
      end
      if (sel_set) begin
         sel_err_d = 1'b1;
      end
   end

   always_comb begin
      tmo_d = tmo_q;
      if (sclk_ev || rclk_ev) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_MAX) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         word_q        <= '0;
         frame_valid_q <= 1'b0;
         bit_count_q   <= '0;
         len_err_q     <= 1'b0;
         sel_err_q     <= 1'b0;
         digit_q       <= '0;
         seg_q         <= '0;
         img_q         <= '0;
         tmo_q         <= '0;
      end else begin
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         word_q        <= word_d;
         frame_valid_q <= frame_valid_d;
         bit_count_q   <= bit_count_d;
         len_err_q     <= len_err_d;
         sel_err_q     <= sel_err_d;
         digit_q       <= digit_d;
         seg_q         <= seg_d;
         img_q         <= img_d;
         tmo_q         <= tmo_d;
      end
   end

   assign word_o        = word_q;
   assign frame_valid_o = frame_valid_q;
   assign bit_count_o   = bit_count_q;
   assign len_err_o     = len_err_q;
   assign sel_err_o     = sel_err_q;
   assign digit_o       = digit_q;
   assign seg_o         = seg_q;
   assign seg_image_o   = img_q;
   assign idle_o        = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_hc595_frame_capture.sv
// Directed bench for hc595_frame_capture: drives 595-style serial frames and checks latch, decode, errors and idle.
module tb_hc595_frame_capture;

   logic        clk;
   logic        rst_n;
   logic        sclk_in, sdata_in, rclk_in, clr_err_i;
   logic [15:0] word_o;
   logic        frame_valid_o;
   logic [4:0]  bit_count_o;
   logic        len_err_o, sel_err_o;
   logic [2:0]  digit_o;
   logic [7:0]  seg_o;
   logic [63:0] seg_image_o;
   logic        idle_o;

   int errors = 0;
   int checks = 0;
   int pulses, lat;

   hc595_frame_capture #(
      .WORD_W(16), .DIGITS(8), .SEG_W(8), .DIG_ACTIVE_LOW(1'b1), .TIMEOUT(16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sclk_in       (sclk_in),
      .sdata_in      (sdata_in),
      .rclk_in       (rclk_in),
      .clr_err_i     (clr_err_i),
      .word_o        (word_o),
      .frame_valid_o (frame_valid_o),
      .bit_count_o   (bit_count_o),
      .len_err_o     (len_err_o),
      .sel_err_o     (sel_err_o),
      .digit_o       (digit_o),
      .seg_o         (seg_o),
      .seg_image_o   (seg_image_o),
      .idle_o        (idle_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends the low n bits of v, MSB first, with 4-cycle setup/high/low phases.
   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sdata_in = v[i];
         cycles(4);
         sclk_in = 1'b1;
         cycles(4);
         sclk_in = 1'b0;
      end
      cycles(4);
   endtask

   // Raises rclk (optionally with sclk on the same edge) and records frame_valid pulses and their latency.
   task automatic pulse_rclk(input bit with_sclk, output int np, output int lt);
      np = 0;
      lt = 0;
      if (with_sclk) sclk_in = 1'b1;
      rclk_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (frame_valid_o === 1'b1) begin
            np++;
            lt = k;
         end
         if (k == 4) begin
            rclk_in = 1'b0;
            sclk_in = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      sclk_in   = 1'b0;
      sdata_in  = 1'b0;
      rclk_in   = 1'b0;
      clr_err_i = 1'b0;
      #2 rst_n = 1'b0;
      cycles(3);
      chk("rst_word", word_o, 16'h0);
      chk("rst_fv", frame_valid_o, 1'b0);
      chk("rst_bitcnt", bit_count_o, 5'd0);
      chk("rst_errs", {len_err_o, sel_err_o}, 2'b00);
      chk("rst_digit_seg", {digit_o, seg_o}, 11'h0);
      chk("rst_image", seg_image_o, 64'h0);
      chk("rst_idle", idle_o, 1'b0);
      rst_n = 1'b1;
      cycles(2);

      // Single frame, digit 0
      send_bits(16'hFE3F, 16);
      pulse_rclk(1'b0, pulses, lat);
      chk("t1_pulses", pulses, 1);
      chk("t1_latency", lat, 3);
      chk("t1_word", word_o, 16'hFE3F);
      chk("t1_bitcnt", bit_count_o, 5'd16);
      chk("t1_len_err", len_err_o, 1'b0);
      chk("t1_digit", digit_o, 3'd0);
      chk("t1_seg", seg_o, 8'h3F);
      chk("t1_img0", seg_image_o[7:0], 8'h3F);

      // Fill all eight digits
      for (int d = 0; d < 8; d++) begin
         logic [7:0] sel;
         sel = ~(8'h01 << d);
         send_bits({sel, 8'(d)}, 16);
         pulse_rclk(1'b0, pulses, lat);
      end
      chk("t2_image", seg_image_o, 64'h0706050403020100);
      chk("t2_sel_err", sel_err_o, 1'b0);
      chk("t2_digit", digit_o, 3'd7);
      chk("t2_seg", seg_o, 8'h07);

      // Short frame; shift register keeps the stale MSB from 16'h7F07
      send_bits(16'h1234, 15);
      pulse_rclk(1'b0, pulses, lat);
      chk("t3_len_err", len_err_o, 1'b1);
      chk("t3_bitcnt", bit_count_o, 5'd15);
      chk("t3_word", word_o, 16'h9234);
      chk("t3_sel_err", sel_err_o, 1'b1);
      chk("t3_seg", seg_o, 8'h34);
      chk("t3_digit_hold", digit_o, 3'd7);
      clr_err_i = 1'b1;
      cycles(1);
      clr_err_i = 1'b0;
      cycles(1);
      chk("t3_cleared", {len_err_o, sel_err_o}, 2'b00);
      send_bits(16'hF711, 16);
      pulse_rclk(1'b0, pulses, lat);
      chk("t3_after_len", len_err_o, 1'b0);
      chk("t3_after_sel", sel_err_o, 1'b0);
      chk("t3_after_digit", digit_o, 3'd3);
      chk("t3_after_img", seg_image_o, 64'h0706050411020100);

      // Two digits selected at once
      send_bits(16'hFC55, 16);
      pulse_rclk(1'b0, pulses, lat);
      chk("t4_word", word_o, 16'hFC55);
      chk("t4_sel_err", sel_err_o, 1'b1);
      chk("t4_seg", seg_o, 8'h55);
      chk("t4_digit", digit_o, 3'd3);
      chk("t4_img", seg_image_o, 64'h0706050411020100);

      // 16th sclk edge coincident with rclk
      send_bits(16'h5FA1, 15);
      sdata_in = 1'b0;
      cycles(4);
      pulse_rclk(1'b1, pulses, lat);
      chk("t5_pulses", pulses, 1);
      chk("t5_word", word_o, 16'hBF42);
      chk("t5_bitcnt", bit_count_o, 5'd16);
      chk("t5_len_err", len_err_o, 1'b0);
      chk("t5_digit", digit_o, 3'd6);
      chk("t5_img", seg_image_o, 64'h0742050411020100);

      // Reset mid-frame, then idle timeout and a clean frame
      send_bits(16'hABCD, 9);
      rst_n = 1'b0;
      cycles(2);
      chk("t6_rst_word", word_o, 16'h0);
      chk("t6_rst_bitcnt", bit_count_o, 5'd0);
      chk("t6_rst_flags", {frame_valid_o, len_err_o, sel_err_o, idle_o}, 4'b0000);
      chk("t6_rst_digit_seg", {digit_o, seg_o}, 11'h0);
      chk("t6_rst_image", seg_image_o, 64'h0);
      rst_n = 1'b1;
      cycles(8);
      chk("t6_not_idle", idle_o, 1'b0);
      cycles(12);
      chk("t6_idle", idle_o, 1'b1);
      sdata_in = 1'b0;
      cycles(4);
      sclk_in = 1'b1;
      cycles(2);
      chk("t6_idle_at_event", idle_o, 1'b1);
      cycles(1);
      chk("t6_idle_cleared", idle_o, 1'b0);
      cycles(1);
      sclk_in = 1'b0;
      cycles(4);
      send_bits(16'h7F80, 15);
      pulse_rclk(1'b0, pulses, lat);
      chk("t6_pulses", pulses, 1);
      chk("t6_word", word_o, 16'h7F80);
      chk("t6_bitcnt", bit_count_o, 5'd16);
      chk("t6_errs", {len_err_o, sel_err_o}, 2'b00);
      chk("t6_digit_seg", {digit_o, seg_o}, {3'd7, 8'h80});
      chk("t6_image", seg_image_o, 64'h8000000000000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
